// File: rtl/agc_cdu_link_pkg.sv
// Shared types and default sizing for the AGC-side CDU link.
// Contents: drive_state_t (drive pulse FSM states) and default width/timing localparams.
package agc_cdu_link_pkg;

  localparam int unsigned DefCntW     = 15;  // angle counter width
  localparam int unsigned DefCmdW     = 9;   // drive command magnitude width
  localparam int unsigned DefPulseDiv = 16;  // clocks per drive pulse period
  localparam int unsigned DefPulseW   = 4;   // clocks a drive pulse is high
  localparam int unsigned DefZeroW    = 8;   // clocks AGCZ is held per zero request

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } drive_state_t;

endpackage

// File: rtl/agc_cdu_link_if.sv
// AGC channel-side bundle of the CDU link.
// master: channel logic (drives eec_en, zero_req, cmd_*; observes status).
// slave : agc_cdu_link (observes requests; drives cmd_busy, cmd_rej, cdu_cnt, cnt_ovf).
interface agc_cdu_link_if import agc_cdu_link_pkg::*; #(
  parameter int unsigned CNT_W = DefCntW,
  parameter int unsigned CMD_W = DefCmdW
) ();

  logic             eec_en;
  logic             zero_req;
  logic             cmd_wr;
  logic             cmd_neg;
  logic [CMD_W-1:0] cmd_cnt;
  logic             cmd_busy;
  logic             cmd_rej;
  logic [CNT_W-1:0] cdu_cnt;
  logic             cnt_ovf;

  modport master (
    output eec_en, zero_req, cmd_wr, cmd_neg, cmd_cnt,
    input  cmd_busy, cmd_rej, cdu_cnt, cnt_ovf
  );

  modport slave (
    input  eec_en, zero_req, cmd_wr, cmd_neg, cmd_cnt,
    output cmd_busy, cmd_rej, cdu_cnt, cnt_ovf
  );

endinterface

// File: rtl/agc_cdu_link_pulse_sync.sv
// Two-flop synchroniser followed by a rising-edge detector for one CDU angle pulse line.
// Ports:
//   clk     in  system clock
//   rst_n   in  synchronous active-low reset
//   i_async in  asynchronous pulse level
//   o_rise  out 1-clk strobe, high the clock after the synchronised level rises
module agc_cdu_link_pulse_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  // A level held high yields exactly one strobe.
  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/agc_cdu_link.sv
// AGC-side end of the CDU angle / error-drive link.
// Counts CDU +/- angle pulses into a wrapping two's-complement counter, issues the AGCZ
// zero discrete, registers the error-counter enable (AGCEEC) and meters +/- drive pulse bursts.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   ATpPGH, ATmPGH  asynchronous CDU angle pulses (rising edge = +1 / -1)
//   AFpPCH, AFmPCH  drive pulses to the CDU
//   AGCZ            zero discrete, ZERO_W clocks per request
//   AGCEEC          eec_en delayed one clock
//   ch              channel-side interface (slave modport)
// Build option: CDU_LINK_OVF_EN enables the sticky wrap flag ch.cnt_ovf; otherwise it is tied 0.
module agc_cdu_link import agc_cdu_link_pkg::*; #(
  parameter int unsigned CNT_W     = DefCntW,
  parameter int unsigned CMD_W     = DefCmdW,
  parameter int unsigned PULSE_DIV = DefPulseDiv,
  parameter int unsigned PULSE_W   = DefPulseW,
  parameter int unsigned ZERO_W    = DefZeroW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ATpPGH,
  input  logic          ATmPGH,
  output logic          AFpPCH,
  output logic          AFmPCH,
  output logic          AGCZ,
  output logic          AGCEEC,
  agc_cdu_link_if.slave ch
);

  localparam int unsigned TickW = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;
  localparam int unsigned ZcntW = $clog2(ZERO_W + 1);

  // Angle counter path
  logic             w_rise_p;
  logic             w_rise_m;
  logic             w_inc;
  logic             w_dec;
  logic             w_zero_act;
  logic [CNT_W-1:0] r_cnt;
  logic [ZcntW-1:0] r_zcnt;
  logic             r_eec;

  agc_cdu_link_pulse_sync u_sync_p (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(ATpPGH),
    .o_rise (w_rise_p)
  );

  agc_cdu_link_pulse_sync u_sync_m (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(ATmPGH),
    .o_rise (w_rise_m)
  );

  // Coincident + and - edges cancel.
  assign w_inc      = w_rise_p & ~w_rise_m;
  assign w_dec      = w_rise_m & ~w_rise_p;
  assign w_zero_act = (r_zcnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_zcnt <= '0;
      r_eec  <= 1'b0;
    end else begin
      r_eec <= ch.eec_en;
      if (ch.zero_req) begin
        r_zcnt <= ZcntW'(ZERO_W);
      end else if (w_zero_act) begin
        r_zcnt <= r_zcnt - ZcntW'(1);
      end
      // Held at zero through the whole AGCZ window; edges seen meanwhile are dropped.
      if (ch.zero_req || w_zero_act) begin
        r_cnt <= '0;
      end else if (w_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_dec) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign ch.cdu_cnt = r_cnt;
  assign AGCZ       = w_zero_act;
  assign AGCEEC     = r_eec;

`ifdef CDU_LINK_OVF_EN
  logic r_ovf;
  logic w_wrap;

  assign w_wrap = !(ch.zero_req || w_zero_act) &&
                  ((w_inc && (r_cnt == '1)) || (w_dec && (r_cnt == '0)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (ch.zero_req) begin
      r_ovf <= 1'b0;
    end else if (w_wrap) begin
      r_ovf <= 1'b1;
    end
  end

  assign ch.cnt_ovf = r_ovf;
`else
  assign ch.cnt_ovf = 1'b0;
`endif

  // Drive pulse FSM
  drive_state_t     r_state;
  drive_state_t     w_state_d;
  logic             r_neg;
  logic             w_neg_d;
  logic [CMD_W-1:0] r_rem;
  logic [CMD_W-1:0] w_rem_d;
  logic [TickW-1:0] r_tick;
  logic [TickW-1:0] w_tick_d;
  logic             r_rej;
  logic             w_rej_d;
  logic             w_drive;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_neg   <= 1'b0;
      r_rem   <= '0;
      r_tick  <= '0;
      r_rej   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_neg   <= w_neg_d;
      r_rem   <= w_rem_d;
      r_tick  <= w_tick_d;
      r_rej   <= w_rej_d;
    end
  end

  // r_tick runs across one whole pulse period: 0..PULSE_W-1 in HIGH, PULSE_W..PULSE_DIV-1 in LOW.
  always_comb begin
    w_state_d = r_state;
    w_neg_d   = r_neg;
    w_rem_d   = r_rem;
    w_tick_d  = r_tick;
    w_rej_d   = 1'b0;
    case (r_state)
      IDLE: begin
        if (ch.cmd_wr && (ch.cmd_cnt != '0)) begin
          if (!r_eec) begin
            w_rej_d = 1'b1;
          end else begin
            w_state_d = HIGH;
            w_neg_d   = ch.cmd_neg;
            w_rem_d   = ch.cmd_cnt;
            w_tick_d  = '0;
          end
        end
      end
      HIGH, LOW: begin
        w_rej_d = ch.cmd_wr;
        if (!r_eec) begin
          w_state_d = IDLE;
          w_rem_d   = '0;
          w_tick_d  = '0;
        end else if (r_state == HIGH) begin
          w_tick_d = r_tick + TickW'(1);
          if (r_tick == TickW'(PULSE_W - 1)) begin
            w_state_d = LOW;
          end
        end else if (r_tick == TickW'(PULSE_DIV - 1)) begin
          w_tick_d  = '0;
          w_rem_d   = r_rem - CMD_W'(1);
          w_state_d = (r_rem == CMD_W'(1)) ? IDLE : HIGH;
        end else begin
          w_tick_d = r_tick + TickW'(1);
        end
      end
      default: begin
        w_state_d = IDLE;
        w_rem_d   = '0;
        w_tick_d  = '0;
      end
    endcase
  end

  // Gating with r_eec drops outputs in the same clock AGCEEC falls, ahead of the state change.
  assign w_drive     = (r_state == HIGH) && r_eec;
  assign AFpPCH      = w_drive & ~r_neg;
  assign AFmPCH      = w_drive & r_neg;
  assign ch.cmd_busy = (r_state != IDLE) && r_eec;
  assign ch.cmd_rej  = r_rej;

endmodule
